mux4x32_rr_arb: RTL and testbench

Round-robin arbiter that shares one 4-input, 32-bit operand multiplexer among four requesters and registers the selected word into a single-entry output buffer with a valid/ready handshake. It computes the mux select each cycle, grants at most one requester per cycle, and tracks the last winner for fairness. It sits between the four 32-bit sources and any downstream consumer that can stall (multi-cycle unit, memory port, debug capture).

---
 rtl/mux4x32_rr_arb_if.sv | 27 ++
 rtl/mux4x32_rr_arb.sv | 102 ++++++++++
 tb/tb_mux4x32_rr_arb.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/mux4x32_rr_arb_if.sv
// Bus bundle for the round-robin operand-mux arbiter: four requesters in,
// one valid/ready output word out.
interface mux4x32_rr_arb_if #(
  parameter int unsigned WIDTH = 32
);
  logic [3:0]       req;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] a2;
  logic [WIDTH-1:0] a3;
  logic [3:0]       gnt;
  logic [1:0]       s;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_src;
  logic             out_valid;
  logic             out_ready;

  modport slave (
    input  req, a0, a1, a2, a3, out_ready,
    output gnt, s, out_data, out_src, out_valid
  );

  modport master (
    output req, a0, a1, a2, a3, out_ready,
    input  gnt, s, out_data, out_src, out_valid
  );
endinterface

// File: rtl/mux4x32_rr_arb.sv
// Round-robin arbiter driving a shared 4:1 operand mux into a single-entry
// registered output buffer with a valid/ready handshake.
module mux4x32_rr_arb #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             clrn,
  mux4x32_rr_arb_if.slave  bus
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} buf_state_e;

  buf_state_e       state_q;
  buf_state_e       state_d;
  logic [1:0]       last_q;
  logic [WIDTH-1:0] data_q;
  logic [1:0]       src_q;

  logic             can_load_c;
  logic             found_c;
  logic             grant_c;
  logic [1:0]       winner_c;
  logic [1:0]       idx_c;
  logic [3:0]       gnt_c;
  logic [1:0]       sel_c;
  logic [WIDTH-1:0] mux_c;

  // Search last+1 .. last+4 (wrapping); first requesting index wins.
  always_comb begin
    winner_c = last_q;
    found_c  = 1'b0;
    idx_c    = '0;
    for (int k = 1; k <= 4; k++) begin
      idx_c = last_q + 2'(k);
      if (!found_c && bus.req[idx_c]) begin
        winner_c = idx_c;
        found_c  = 1'b1;
      end
    end
  end

  // clrn gates the grant so nothing is consumed while reset is held.
  assign can_load_c = (state_q == EMPTY) || bus.out_ready;
  assign grant_c    = clrn && can_load_c && found_c;

  // Buffer state register.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  // Buffer next state.
  always_comb begin
    state_d = state_q;
    if (grant_c)
      state_d = FULL;
    else if (state_q == FULL && bus.out_ready)
      state_d = EMPTY;
  end

  // Grant and mux select outputs.
  always_comb begin
    gnt_c = '0;
    sel_c = '0;
    if (grant_c) begin
      gnt_c = 4'b0001 << winner_c;
      sel_c = winner_c;
    end
  end

  // Shared 4:1 operand mux; the only path into the output buffer.
  always_comb begin
    mux_c = '0;
    case (sel_c)
      2'd0: mux_c = bus.a0;
      2'd1: mux_c = bus.a1;
      2'd2: mux_c = bus.a2;
      2'd3: mux_c = bus.a3;
      default: mux_c = '0;
    endcase
  end

  // Output word and fairness pointer; hold on drain or stall.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      last_q <= 2'b11;
      data_q <= '0;
      src_q  <= '0;
    end else if (grant_c) begin
      last_q <= winner_c;
      data_q <= mux_c;
      src_q  <= winner_c;
    end
  end

  assign bus.gnt       = gnt_c;
  assign bus.s         = sel_c;
  assign bus.out_data  = data_q;
  assign bus.out_src   = src_q;
  assign bus.out_valid = (state_q == FULL);

endmodule

// File: tb/tb_mux4x32_rr_arb.sv
// Bench for mux4x32_rr_arb: directed vector table, hand-written corner
// sequences, then randomized traffic against a rule-level reference model.
module tb_mux4x32_rr_arb;

  logic clk;
  logic clrn;
  int   n_cmp;
  int   n_bad;

  mux4x32_rr_arb_if #(.WIDTH(32)) bus ();

  mux4x32_rr_arb #(.WIDTH(32)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] req;
    logic       rdy;
    logic [3:0] exp_gnt;
    logic       exp_valid;
    logic [1:0] exp_src;
  } vec_t;

  vec_t vecs[14];

  // Reference model: arbitration by rotating priority from the last winner.
  int          m_last;
  bit          m_valid;
  logic [31:0] m_data;
  logic [1:0]  m_src;
  logic [31:0] dat[4];
  bit          pend[4];
  int          wait_cnt[4];

  function automatic int pick(input logic [3:0] r, input int last);
    int order[4];
    for (int k = 0; k < 4; k++) order[k] = (last + 1 + k) % 4;
    for (int k = 0; k < 4; k++) if (r[order[k]]) return order[k];
    return -1;
  endfunction

  task automatic drive_a();
    bus.a0 = dat[0];
    bus.a1 = dat[1];
    bus.a2 = dat[2];
    bus.a3 = dat[3];
  endtask

  initial begin
    logic [3:0]  r;
    logic        rdy;
    int          w;
    logic [3:0]  eg;
    logic [1:0]  es;
    logic [31:0] held;

    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < 4; i++) dat[i] = 32'hA000_0000 + 32'(i);
    drive_a();

    // Reset held with all requests up: nothing granted, buffer cleared.
    clrn = 1'b0;
    bus.req = 4'b1111;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_gnt",   32'(bus.gnt), 32'h0);
    chk("rst_s",     32'(bus.s), 32'h0);
    chk("rst_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_data",  bus.out_data, 32'h0);
    chk("rst_src",   32'(bus.out_src), 32'h0);
    bus.req = 4'b0000;
    clrn = 1'b1;

    vecs[0]  = '{4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0};
    vecs[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
    vecs[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
    vecs[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3};
    vecs[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
    vecs[5]  = '{4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1};
    vecs[6]  = '{4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3};
    vecs[7]  = '{4'b0100, 1'b0, 4'b0000, 1'b1, 2'd3};
    vecs[8]  = '{4'b0100, 1'b0, 4'b0000, 1'b1, 2'd3};
    vecs[9]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2};
    vecs[10] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2};
    vecs[11] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd2};
    vecs[12] = '{4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0};
    vecs[13] = '{4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0};

    foreach (vecs[i]) begin
      @(negedge clk);
      bus.req = vecs[i].req;
      bus.out_ready = vecs[i].rdy;
      #1;
      chk($sformatf("vec%0d_gnt", i), 32'(bus.gnt), 32'(vecs[i].exp_gnt));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_src", i), 32'(bus.out_src), 32'(vecs[i].exp_src));
      chk($sformatf("vec%0d_data", i), bus.out_data, 32'hA000_0000 + 32'(vecs[i].exp_src));
    end

    // Stall five cycles with a pending request, then release: same-cycle grant.
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bus.req = 4'b0100;
      bus.out_ready = 1'b0;
      #1;
      chk("stall_gnt", 32'(bus.gnt), 32'h0);
      chk("stall_data", bus.out_data, 32'hA000_0000);
      chk("stall_valid", 32'(bus.out_valid), 32'h1);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    #1;
    chk("unstall_gnt", 32'(bus.gnt), 32'h4);
    chk("unstall_s", 32'(bus.s), 32'h2);
    @(posedge clk); #1;
    chk("unstall_data", bus.out_data, 32'hA000_0002);
    chk("unstall_src", 32'(bus.out_src), 32'h2);

    // Drain with no request: valid falls, data holds.
    @(negedge clk);
    bus.req = 4'b0000;
    @(posedge clk); #1;
    chk("drain_valid", 32'(bus.out_valid), 32'h0);
    chk("drain_data", bus.out_data, 32'hA000_0002);

    // Refill, then asynchronous reset between edges.
    @(negedge clk);
    bus.req = 4'b1111;
    @(posedge clk); #1;
    chk("refill_src", 32'(bus.out_src), 32'h3);
    @(negedge clk);
    bus.req = 4'b1001;
    clrn = 1'b0;
    #1;
    chk("midrst_valid", 32'(bus.out_valid), 32'h0);
    chk("midrst_data", bus.out_data, 32'h0);
    chk("midrst_gnt", 32'(bus.gnt), 32'h0);
    clrn = 1'b1;
    #1;
    chk("postrst_low_wins", 32'(bus.gnt), 32'h1);
    bus.req = 4'b1000;
    #1;
    chk("postrst_gnt3", 32'(bus.gnt), 32'h8);
    @(posedge clk); #1;
    chk("postrst_src", 32'(bus.out_src), 32'h3);
    chk("postrst_data", bus.out_data, 32'hA000_0003);

    // Randomized traffic against the reference model.
    @(negedge clk);
    bus.req = 4'b0000;
    clrn = 1'b0;
    #1;
    clrn = 1'b1;
    m_last = 3; m_valid = 0; m_data = 32'h0; m_src = 2'd0;
    for (int i = 0; i < 4; i++) begin pend[i] = 0; wait_cnt[i] = 0; end

    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (!pend[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            pend[i] = 1;
            dat[i] = $urandom;
            wait_cnt[i] = 0;
          end
        end else if ($urandom_range(0, 9) == 0) begin
          pend[i] = 0;
          wait_cnt[i] = 0;
        end
      end
      r = {pend[3], pend[2], pend[1], pend[0]};
      rdy = ($urandom_range(0, 3) != 0);
      bus.req = r;
      bus.out_ready = rdy;
      drive_a();
      #1;
      w = (!m_valid || rdy) ? pick(r, m_last) : -1;
      eg = (w >= 0) ? (4'b0001 << w) : 4'b0000;
      es = (w >= 0) ? 2'(w) : 2'd0;
      chk("rnd_gnt", 32'(bus.gnt), 32'(eg));
      chk("rnd_s", 32'(bus.s), 32'(es));
      chk("rnd_valid", 32'(bus.out_valid), 32'(m_valid));
      chk("rnd_data", bus.out_data, m_data);
      chk("rnd_src", 32'(bus.out_src), 32'(m_src));
      held = dat[(w >= 0) ? w : 0];
      @(posedge clk);
      if (w >= 0) begin
        chk("rnd_fair", 32'(wait_cnt[w] <= 3), 32'h1);
        for (int i = 0; i < 4; i++) if (i != w && pend[i]) wait_cnt[i]++;
        wait_cnt[w] = 0;
        pend[w] = 0;
        m_data = held;
        m_src = 2'(w);
        m_valid = 1;
        m_last = w;
      end else if (m_valid && rdy) begin
        m_valid = 0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
